// File: rtl/fifo_to_mem_mq_pkg.sv
// Shared definitions for the multi-queue FIFO-to-SRAM writer.
package fifo_to_mem_mq_pkg;

  // Largest queue count the qid field and register map are laid out for.
  localparam int unsigned MaxQueues = 16;

  // Per-queue action for the current pop, decoded once and shared by all next-state terms.
  typedef enum logic [1:0] {
    QIdle,     // no word for this queue this cycle
    QWrite,    // word goes to SRAM
    QDiscard,  // word thrown away, packet continues
    QDropEnd   // last word of a thrown-away packet
  } q_act_e;

  // ceil(log2(n)), never below 1 so a single-queue build still has a qid bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_to_mem_qptr.sv
// Per-queue write pointer, full/drop tracking and packet/drop counters.
module fifo_to_mem_qptr
  import fifo_to_mem_mq_pkg::*;
#(
  parameter int unsigned AddrWidth = 19,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sw_rst,
  input  logic                 hit,
  input  logic                 eop,
  input  logic                 enable,
  input  logic                 wrap_en,
  input  logic [AddrWidth-1:0] low,
  input  logic [AddrWidth-1:0] high,
  output logic                 wr_ok,
  output logic [AddrWidth-1:0] ptr,
  output logic                 full,
  output logic [CntWidth-1:0]  pkt_cnt,
  output logic [CntWidth-1:0]  drop_cnt
);

  // Counters stick at all-ones instead of rolling over.
  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [AddrWidth-1:0] ptr_q, ptr_d;
  logic                 full_q, full_d;
  logic                 drop_q, drop_d;
  logic [CntWidth-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CntWidth-1:0]  drop_cnt_q, drop_cnt_d;
  logic                 at_end;
  q_act_e               act;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (v == CntMax) ? v : v + CntWidth'(1);
  endfunction

  // A word may land only while the region has room and no packet is being thrown away.
  assign wr_ok  = enable & ~full_q & ~drop_q;
  assign at_end = (ptr_q == high - AddrWidth'(1));

  assign ptr      = ptr_q;
  assign full     = full_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

  // Classify this cycle's pop for this queue.
  always_comb begin
    act = QIdle;
    if (hit && enable) begin
      if (wr_ok) begin
        act = QWrite;
      end else if (eop) begin
        act = QDropEnd;
      end else begin
        act = QDiscard;
      end
    end
  end

  // Next-state for pointer, flags and counters.
  always_comb begin
    ptr_d      = ptr_q;
    full_d     = full_q;
    drop_d     = drop_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    unique case (act)
      QIdle: begin
      end
      QWrite: begin
        if (at_end) begin
          if (wrap_en) begin
            ptr_d = low;
          end else begin
            // Hold the pointer on the last slot; full blocks further writes.
            full_d = 1'b1;
          end
        end else begin
          ptr_d = ptr_q + AddrWidth'(1);
        end
        if (eop) begin
          pkt_cnt_d = sat_inc(pkt_cnt_q);
        end
      end
      QDiscard: begin
        drop_d = 1'b1;
      end
      QDropEnd: begin
        // A truncated packet is counted once here and never as stored.
        drop_d     = 1'b0;
        drop_cnt_d = sat_inc(drop_cnt_q);
      end
      default: begin
      end
    endcase
  end

  // State register; a disabled queue is held in its reset state.
  always_ff @(posedge clk) begin
    if (!rst_n || sw_rst || !enable) begin
      ptr_q      <= low;
      full_q     <= 1'b0;
      drop_q     <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      full_q     <= full_d;
      drop_q     <= drop_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: rtl/fifo_to_mem_mq.sv
// Multi-queue FWFT packet FIFO drain into per-queue SRAM regions.
module fifo_to_mem_mq
  import fifo_to_mem_mq_pkg::*;
#(
  parameter int unsigned NUM_QUEUES      = 4,
  parameter int unsigned NUM_QUEUES_BITS = clog2_min1(NUM_QUEUES),
  parameter int unsigned FIFO_DATA_WIDTH = 144,
  parameter int unsigned MEM_ADDR_WIDTH  = 19,
  parameter int unsigned MEM_DATA_WIDTH  = 72,
  parameter int unsigned MEM_BW_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  output logic                                 fifo_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0]           fifo_data,
  input  logic [NUM_QUEUES_BITS-1:0]           fifo_qid,
  input  logic                                 fifo_eop,
  input  logic                                 fifo_empty,
  input  logic                                 mem_wr_full,
  output logic                                 mem_ad_w_n,
  output logic                                 mem_d_w_n,
  output logic [MEM_ADDR_WIDTH-1:0]            mem_ad_wr,
  output logic [MEM_DATA_WIDTH-1:0]            mem_dwl,
  output logic [MEM_DATA_WIDTH-1:0]            mem_dwh,
  output logic [MEM_BW_WIDTH-1:0]              mem_bwl_n,
  output logic [MEM_BW_WIDTH-1:0]              mem_bwh_n,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_low,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_high,
  input  logic [NUM_QUEUES-1:0]                q_enable,
  input  logic [NUM_QUEUES-1:0]                q_wrap_en,
  output logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_wr_ptr,
  output logic [NUM_QUEUES-1:0]                q_full,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]      q_pkt_cnt,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]      q_drop_cnt,
  input  logic                                 sw_rst,
  input  logic                                 cal_done
);

  logic [NUM_QUEUES-1:0]     hit;
  logic [NUM_QUEUES-1:0]     wr_ok;
  logic                      wr_sel;
  logic [MEM_ADDR_WIDTH-1:0] addr_sel;

  logic                      we_n_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_DATA_WIDTH-1:0] dwl_q, dwh_q;

  // Every word leaves the FIFO through this strobe, whether it is written or discarded.
  assign fifo_rd_en = ~fifo_empty & ~mem_wr_full & cal_done;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_queue
    // An out-of-range qid matches no queue, so its word is popped and ignored.
    assign hit[i] = fifo_rd_en & (fifo_qid == NUM_QUEUES_BITS'(i));

    fifo_to_mem_qptr #(
      .AddrWidth (MEM_ADDR_WIDTH),
      .CntWidth  (CNT_WIDTH)
    ) u_qptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_rst   (sw_rst),
      .hit      (hit[i]),
      .eop      (fifo_eop),
      .enable   (q_enable[i]),
      .wrap_en  (q_wrap_en[i]),
      .low      (q_addr_low[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH]),
      .high     (q_addr_high[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH]),
      .wr_ok    (wr_ok[i]),
      .ptr      (q_wr_ptr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH]),
      .full     (q_full[i]),
      .pkt_cnt  (q_pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .drop_cnt (q_drop_cnt[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  // At most one hit bit is set, so the selected queue's pointer is an OR of masked pointers.
  assign wr_sel = |(hit & wr_ok);

  // Pick the write address of the queue owning the current word.
  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (hit[i]) begin
        addr_sel = addr_sel | q_wr_ptr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
      end
    end
  end

  // Registered SRAM write port: strobes one cycle after the pop.
  always_ff @(posedge clk) begin
    if (!rst_n || sw_rst) begin
      we_n_q <= 1'b1;
      addr_q <= '0;
      dwl_q  <= '0;
      dwh_q  <= '0;
    end else begin
      we_n_q <= ~wr_sel;
      if (wr_sel) begin
        addr_q <= addr_sel;
        dwl_q  <= fifo_data[MEM_DATA_WIDTH-1:0];
        dwh_q  <= fifo_data[FIFO_DATA_WIDTH-1:MEM_DATA_WIDTH];
      end
    end
  end

  assign mem_ad_w_n = we_n_q;
  assign mem_d_w_n  = we_n_q;
  assign mem_ad_wr  = addr_q;
  assign mem_dwl    = dwl_q;
  assign mem_dwh    = dwh_q;
  assign mem_bwl_n  = '0;
  assign mem_bwh_n  = '0;

endmodule

// File: tb/tb_fifo_to_mem_mq.sv
// Scoreboard bench for fifo_to_mem_mq: expected SRAM writes are queued with the stimulus.
module tb_fifo_to_mem_mq;

  localparam int unsigned NQ = 4;
  localparam int unsigned QB = 2;
  localparam int unsigned FW = 144;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 72;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 32;

  typedef logic [255:0] val_t;

  typedef struct {
    logic [FW-1:0] data;
    logic [QB-1:0] qid;
    logic          eop;
  } word_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [FW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, sw_rst, cal_done, mem_wr_full;
  logic             fifo_rd_en, fifo_eop, fifo_empty;
  logic [FW-1:0]    fifo_data;
  logic [QB-1:0]    fifo_qid;
  logic             mem_ad_w_n, mem_d_w_n;
  logic [AW-1:0]    mem_ad_wr;
  logic [DW-1:0]    mem_dwl, mem_dwh;
  logic [BW-1:0]    mem_bwl_n, mem_bwh_n;
  logic [NQ*AW-1:0] q_addr_low, q_addr_high, q_wr_ptr;
  logic [NQ-1:0]    q_enable, q_wrap_en, q_full;
  logic [NQ*CW-1:0] q_pkt_cnt, q_drop_cnt;

  word_t fifo_q[$];
  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;

  fifo_to_mem_mq #(
    .NUM_QUEUES      (NQ),
    .NUM_QUEUES_BITS (QB),
    .FIFO_DATA_WIDTH (FW),
    .MEM_ADDR_WIDTH  (AW),
    .MEM_DATA_WIDTH  (DW),
    .MEM_BW_WIDTH    (BW),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_data   (fifo_data),
    .fifo_qid    (fifo_qid),
    .fifo_eop    (fifo_eop),
    .fifo_empty  (fifo_empty),
    .mem_wr_full (mem_wr_full),
    .mem_ad_w_n  (mem_ad_w_n),
    .mem_d_w_n   (mem_d_w_n),
    .mem_ad_wr   (mem_ad_wr),
    .mem_dwl     (mem_dwl),
    .mem_dwh     (mem_dwh),
    .mem_bwl_n   (mem_bwl_n),
    .mem_bwh_n   (mem_bwh_n),
    .q_addr_low  (q_addr_low),
    .q_addr_high (q_addr_high),
    .q_enable    (q_enable),
    .q_wrap_en   (q_wrap_en),
    .q_wr_ptr    (q_wr_ptr),
    .q_full      (q_full),
    .q_pkt_cnt   (q_pkt_cnt),
    .q_drop_cnt  (q_drop_cnt),
    .sw_rst      (sw_rst),
    .cal_done    (cal_done)
  );

  task automatic check(input string tag, input val_t got, input val_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] ptr_of(input int i);
    return q_wr_ptr[i*AW +: AW];
  endfunction

  function automatic logic [CW-1:0] pkt_of(input int i);
    return q_pkt_cnt[i*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] drop_of(input int i);
    return q_drop_cnt[i*CW +: CW];
  endfunction

  // FWFT model: head of fifo_q is presented shortly after each falling edge.
  always @(negedge clk) begin
    #1;
    if (fifo_q.size() > 0) begin
      fifo_empty = 1'b0;
      fifo_data  = fifo_q[0].data;
      fifo_qid   = fifo_q[0].qid;
      fifo_eop   = fifo_q[0].eop;
    end else begin
      fifo_empty = 1'b1;
      fifo_data  = '0;
      fifo_qid   = '0;
      fifo_eop   = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
    end
  end

  // Every SRAM strobe must match the oldest expected write.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!mem_ad_w_n) begin
      check("d_w_n", val_t'(mem_d_w_n), val_t'(0));
      if (exp_q.size() == 0) begin
        check("unexpected_wr", val_t'(mem_ad_w_n), val_t'(1));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", val_t'(mem_ad_wr), val_t'(e.addr));
        check("wr_data", val_t'({mem_dwh, mem_dwl}), val_t'(e.data));
      end
    end
  end

  task automatic push_word(input int q, input logic eop, input logic exp_wr, input int addr);
    word_t         w;
    exp_t          e;
    logic [159:0]  r;
    r      = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w.data = r[FW-1:0];
    w.qid  = QB'(q);
    w.eop  = eop;
    fifo_q.push_back(w);
    if (exp_wr) begin
      e.addr = AW'(addr);
      e.data = w.data;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (fifo_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", val_t'(fifo_q.size()), val_t'(0));
    repeat (3) @(negedge clk);
    check("missing_wr", val_t'(exp_q.size()), val_t'(0));
  endtask

  task automatic clear_q(input int q, input logic wrap);
    @(negedge clk);
    q_enable[q]  = 1'b0;
    q_wrap_en[q] = wrap;
    @(negedge clk);
    q_enable[q] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    sw_rst      = 1'b0;
    cal_done    = 1'b1;
    mem_wr_full = 1'b0;
    q_enable    = '1;
    q_wrap_en   = '0;
    q_addr_low  = {19'h400, 19'h300, 19'h200, 19'h100};
    q_addr_high = {19'h420, 19'h310, 19'h220, 19'h104};
    fifo_empty  = 1'b1;
    fifo_data   = '0;
    fifo_qid    = '0;
    fifo_eop    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ad_w_n", val_t'(mem_ad_w_n), val_t'(1));
    check("rst_d_w_n", val_t'(mem_d_w_n), val_t'(1));
    check("rst_addr", val_t'(mem_ad_wr), val_t'(0));
    check("rst_data", val_t'({mem_dwh, mem_dwl}), val_t'(0));
    check("rst_ptr", val_t'(q_wr_ptr), val_t'({19'h400, 19'h300, 19'h200, 19'h100}));
    check("rst_full", val_t'(q_full), val_t'(0));
    check("rst_pkt", val_t'(q_pkt_cnt), val_t'(0));
    check("rst_drop", val_t'(q_drop_cnt), val_t'(0));
    check("rst_rd_en", val_t'(fifo_rd_en), val_t'(0));
    rst_n = 1'b1;

    // Calibration gate holds the pop
    @(negedge clk);
    cal_done = 1'b0;
    push_word(2, 1'b1, 1'b1, 'h300);
    repeat (3) begin
      @(negedge clk);
      #2;
      check("cal_hold_rd_en", val_t'(fifo_rd_en), val_t'(0));
    end
    cal_done = 1'b1;
    drain();
    check("cal_pkt2", val_t'(pkt_of(2)), val_t'(1));

    // Non-wrap fill: 4 writes then 2 drops
    @(negedge clk);
    for (int k = 0; k < 6; k++) push_word(0, 1'b1, k < 4, 'h100 + k);
    drain();
    check("t1_full", val_t'(q_full[0]), val_t'(1));
    check("t1_pkt", val_t'(pkt_of(0)), val_t'(4));
    check("t1_drop", val_t'(drop_of(0)), val_t'(2));
    check("t1_ptr", val_t'(ptr_of(0)), val_t'('h103));

    // Wrap mode
    clear_q(0, 1'b1);
    for (int k = 0; k < 6; k++) push_word(0, 1'b1, 1'b1, 'h100 + (k % 4));
    drain();
    check("t2_pkt", val_t'(pkt_of(0)), val_t'(6));
    check("t2_ptr", val_t'(ptr_of(0)), val_t'('h102));
    check("t2_full", val_t'(q_full[0]), val_t'(0));
    check("t2_drop", val_t'(drop_of(0)), val_t'(0));

    // Packet truncated by region full, then a whole packet dropped
    clear_q(0, 1'b0);
    push_word(0, 1'b1, 1'b1, 'h100);
    push_word(0, 1'b1, 1'b1, 'h101);
    push_word(0, 1'b0, 1'b1, 'h102);
    push_word(0, 1'b0, 1'b1, 'h103);
    push_word(0, 1'b1, 1'b0, 0);
    drain();
    check("t3_pkt", val_t'(pkt_of(0)), val_t'(2));
    check("t3_drop", val_t'(drop_of(0)), val_t'(1));
    check("t3_full", val_t'(q_full[0]), val_t'(1));
    @(negedge clk);
    push_word(0, 1'b1, 1'b0, 0);
    drain();
    check("t3_drop2", val_t'(drop_of(0)), val_t'(2));
    check("t3_pkt2", val_t'(pkt_of(0)), val_t'(2));

    // Interleaved q1/q3 with write backpressure mid-packet
    @(negedge clk);
    push_word(1, 1'b0, 1'b1, 'h200);
    push_word(3, 1'b0, 1'b1, 'h400);
    push_word(1, 1'b0, 1'b1, 'h201);
    drain();
    @(negedge clk);
    mem_wr_full = 1'b1;
    push_word(3, 1'b0, 1'b1, 'h401);
    push_word(1, 1'b1, 1'b1, 'h202);
    push_word(3, 1'b1, 1'b1, 'h402);
    repeat (3) begin
      @(negedge clk);
      #2;
      check("t4_bp_rd_en", val_t'(fifo_rd_en), val_t'(0));
      check("t4_bp_strobe", val_t'(mem_ad_w_n), val_t'(1));
    end
    mem_wr_full = 1'b0;
    drain();
    check("t4_pkt1", val_t'(pkt_of(1)), val_t'(1));
    check("t4_pkt3", val_t'(pkt_of(3)), val_t'(1));
    check("t4_ptr1", val_t'(ptr_of(1)), val_t'('h203));
    check("t4_ptr3", val_t'(ptr_of(3)), val_t'('h403));

    // Disabled queue: words are popped and discarded
    @(negedge clk);
    q_enable[2] = 1'b0;
    for (int k = 0; k < 5; k++) push_word(2, k == 4, 1'b0, 0);
    drain();
    check("t5_pkt", val_t'(pkt_of(2)), val_t'(0));
    check("t5_drop", val_t'(drop_of(2)), val_t'(0));
    check("t5_ptr", val_t'(ptr_of(2)), val_t'('h300));
    @(negedge clk);
    q_enable[2] = 1'b1;
    push_word(2, 1'b1, 1'b1, 'h300);
    drain();
    check("t5_pkt_re", val_t'(pkt_of(2)), val_t'(1));

    // Software reset mid-packet
    clear_q(0, 1'b0);
    push_word(0, 1'b0, 1'b1, 'h100);
    push_word(0, 1'b0, 1'b1, 'h101);
    push_word(0, 1'b0, 1'b1, 'h102);
    drain();
    check("t6_ptr_pre", val_t'(ptr_of(0)), val_t'('h103));
    @(negedge clk);
    sw_rst = 1'b1;
    push_word(0, 1'b0, 1'b0, 0);
    @(negedge clk);
    sw_rst = 1'b0;
    #2;
    check("t6_popped", val_t'(fifo_q.size()), val_t'(0));
    check("t6_strobe", val_t'(mem_ad_w_n), val_t'(1));
    check("t6_ptr", val_t'(ptr_of(0)), val_t'('h100));
    check("t6_pkt", val_t'(q_pkt_cnt), val_t'(0));
    check("t6_drop", val_t'(q_drop_cnt), val_t'(0));
    push_word(0, 1'b0, 1'b1, 'h100);
    push_word(0, 1'b1, 1'b1, 'h101);
    drain();
    check("t6_pkt_after", val_t'(pkt_of(0)), val_t'(1));
    check("t6_ptr_after", val_t'(ptr_of(0)), val_t'('h102));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
